// File: rtl/cdb_arbiter.sv
// Purpose : shares NUM_CDB registered common-data-bus lanes among NUM_FU result ports,
//           one holding register per FU, round-robin grant of up to NUM_CDB per cycle.
// Latency : handshake t -> cdb_valid t+2 (t+1 for a bypass grant when CDB_ARB_BYPASS_EN is defined).
// Backpressure: fu_ready[i] = ~hold_valid[i] | grant[i]; never depends on fu_valid[i].
// Ports   : clk, rst (sync, active-high), flush (same effect as rst);
//           fu_valid/fu_tag/fu_data in, fu_ready out; cdb_valid/cdb_tag/cdb_data/cdb_src out (registered).
// Option  : `define CDB_ARB_BYPASS_EN lets an FU with an empty hold compete directly from its inputs.
module cdb_arbiter #(
    parameter int NUM_FU    = 6,
    parameter int NUM_CDB   = 4,
    parameter int ROB_DEPTH = 16,
    localparam int TAG_W    = $clog2(ROB_DEPTH),
    localparam int SRC_W    = $clog2(NUM_FU)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic [NUM_FU-1:0]                 fu_valid,
    input  logic [NUM_FU-1:0][TAG_W-1:0]      fu_tag,
    input  logic [NUM_FU-1:0][31:0]           fu_data,
    output logic [NUM_FU-1:0]                 fu_ready,
    output logic [NUM_CDB-1:0]                cdb_valid,
    output logic [NUM_CDB-1:0][TAG_W-1:0]     cdb_tag,
    output logic [NUM_CDB-1:0][31:0]          cdb_data,
    output logic [NUM_CDB-1:0][SRC_W-1:0]     cdb_src
);

    logic [NUM_FU-1:0]                 hold_valid;
    logic [NUM_FU-1:0][TAG_W-1:0]      hold_tag;
    logic [NUM_FU-1:0][31:0]           hold_data;
    logic [SRC_W-1:0]                  rr_ptr;
    logic [SRC_W-1:0]                  rr_next;

    logic [NUM_FU-1:0]                 grant;
    logic [NUM_FU-1:0]                 grant_byp;   // granted straight from the FU inputs
    logic [NUM_CDB-1:0]                lane_vld;
    logic [NUM_CDB-1:0][TAG_W-1:0]     lane_tag;
    logic [NUM_CDB-1:0][31:0]          lane_data;
    logic [NUM_CDB-1:0][SRC_W-1:0]     lane_src;

    // Round-robin scan starting at rr_ptr; the k-th winner lands on lane k so
    // occupied lanes are always contiguous from lane 0.
    always_comb begin
        int               cnt;
        logic [SRC_W:0]   idx_sum;
        logic [SRC_W-1:0] idx;
        logic             cand;
        logic             byp;
        grant     = '0;
        grant_byp = '0;
        lane_vld  = '0;
        lane_tag  = '0;
        lane_data = '0;
        lane_src  = '0;
        rr_next   = rr_ptr;
        cnt       = 0;
        idx_sum   = '0;
        idx       = '0;
        cand      = 1'b0;
        byp       = 1'b0;
        for (int j = 0; j < NUM_FU; j++) begin
            // Explicit wrap so any NUM_FU works, not only powers of two.
            idx_sum = {1'b0, rr_ptr} + (SRC_W+1)'(j);
            if (idx_sum >= (SRC_W+1)'(NUM_FU)) begin
                idx_sum = idx_sum - (SRC_W+1)'(NUM_FU);
            end
            idx = idx_sum[SRC_W-1:0];
`ifdef CDB_ARB_BYPASS_EN
            byp  = ~hold_valid[idx] & fu_valid[idx];
            cand = hold_valid[idx] | byp;
`else
            byp  = 1'b0;
            cand = hold_valid[idx];
`endif
            if (cand && cnt < NUM_CDB) begin
                grant[idx]     = 1'b1;
                grant_byp[idx] = byp;
                for (int k = 0; k < NUM_CDB; k++) begin
                    if (k == cnt) begin
                        lane_vld[k]  = 1'b1;
                        lane_src[k]  = idx;
                        lane_tag[k]  = byp ? fu_tag[idx]  : hold_tag[idx];
                        lane_data[k] = byp ? fu_data[idx] : hold_data[idx];
                    end
                end
                rr_next = (idx == SRC_W'(NUM_FU-1)) ? '0 : idx + 1'b1;
                cnt++;
            end
        end
    end

    assign fu_ready = ~hold_valid | grant;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            hold_valid <= '0;
            hold_tag   <= '0;
            hold_data  <= '0;
            rr_ptr     <= '0;
            cdb_valid  <= '0;
            cdb_tag    <= '0;
            cdb_data   <= '0;
            cdb_src    <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                // A bypass winner goes to the lane only; a new result arriving
                // while the old one is granted overwrites it and stays valid.
                if (fu_valid[i] && fu_ready[i] && !grant_byp[i]) begin
                    hold_valid[i] <= 1'b1;
                    hold_tag[i]   <= fu_tag[i];
                    hold_data[i]  <= fu_data[i];
                end else if (grant[i]) begin
                    hold_valid[i] <= 1'b0;
                end
            end
            rr_ptr    <= rr_next;
            cdb_valid <= lane_vld;
            cdb_tag   <= lane_tag;
            cdb_data  <= lane_data;
            cdb_src   <= lane_src;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Purpose : self-checking bench for cdb_arbiter: directed scenarios plus a long
//           random run, all compared against a queue-free behavioural model.
// Latency : model tracks hold/lane state per cycle; bypass build expects 1 cycle, default 2.
module tb_cdb_arbiter;
    localparam int NF = 6;
    localparam int NC = 4;
    localparam int TW = 4;
    localparam int SW = 3;
`ifdef CDB_ARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int L = BYP ? 1 : 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    flush;
    logic [NF-1:0]           fu_valid;
    logic [NF-1:0][TW-1:0]   fu_tag;
    logic [NF-1:0][31:0]     fu_data;
    logic [NF-1:0]           fu_ready;
    logic [NC-1:0]           cdb_valid;
    logic [NC-1:0][TW-1:0]   cdb_tag;
    logic [NC-1:0][31:0]     cdb_data;
    logic [NC-1:0][SW-1:0]   cdb_src;

    int errors = 0;
    int checks = 0;

    cdb_arbiter #(.NUM_FU(NF), .NUM_CDB(NC), .ROB_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_data(fu_data), .fu_ready(fu_ready),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_src(cdb_src)
    );

    always #5 clk = ~clk;

    // Behavioural model: per-FU hold slots, a pointer, and the registered lanes.
    bit          m_hv[NF];
    logic [TW-1:0] m_ht[NF];
    logic [31:0] m_hd[NF];
    int          m_rr;
    bit          m_cv[NC];
    logic [TW-1:0] m_ct[NC];
    logic [31:0] m_cd[NC];
    int          m_cs[NC];
    logic [NF-1:0] hs;   // handshakes of the last stepped cycle

    task automatic model_clear();
        for (int i = 0; i < NF; i++) begin m_hv[i] = 0; m_ht[i] = '0; m_hd[i] = '0; end
        for (int k = 0; k < NC; k++) begin m_cv[k] = 0; m_ct[k] = '0; m_cd[k] = '0; m_cs[k] = 0; end
        m_rr = 0;
    endtask

    // One clock cycle: compare at the falling edge, advance the model at the rising edge.
    task automatic step();
        int   g_n;
        int   g_idx[NC];
        bit   g_byp[NC];
        bit   g_mask[NF];
        bit   g_bm[NF];
        logic [NF-1:0] exp_rdy;
        logic [SW-1:0] es;
        @(negedge clk);
        g_n = 0;
        for (int i = 0; i < NF; i++) begin g_mask[i] = 0; g_bm[i] = 0; end
        for (int j = 0; j < NF; j++) begin
            int i;
            bit from_in;
            i = (m_rr + j) % NF;
            from_in = !m_hv[i] && BYP && fu_valid[i];
            if ((m_hv[i] || from_in) && g_n < NC) begin
                g_idx[g_n] = i; g_byp[g_n] = from_in;
                g_mask[i] = 1; g_bm[i] = from_in;
                g_n++;
            end
        end
        for (int i = 0; i < NF; i++) exp_rdy[i] = !m_hv[i] || g_mask[i];
        checks++;
        if (fu_ready !== exp_rdy) begin
            errors++;
            $display("FAIL fu_ready: got %b expected %b", fu_ready, exp_rdy);
        end
        for (int k = 0; k < NC; k++) begin
            es = SW'(m_cs[k]);
            checks++;
            if ({cdb_valid[k], cdb_tag[k], cdb_data[k], cdb_src[k]} !== {m_cv[k], m_ct[k], m_cd[k], es}) begin
                errors++;
                $display("FAIL lane%0d: got v=%b t=%h d=%h s=%0d expected v=%b t=%h d=%h s=%0d",
                         k, cdb_valid[k], cdb_tag[k], cdb_data[k], cdb_src[k], m_cv[k], m_ct[k], m_cd[k], es);
            end
        end
        hs = fu_valid & exp_rdy;
        @(posedge clk);
        if (rst || flush) begin
            model_clear();
        end else begin
            for (int k = 0; k < NC; k++) begin
                if (k < g_n) begin
                    int i;
                    i = g_idx[k];
                    m_cv[k] = 1; m_cs[k] = i;
                    m_ct[k] = g_byp[k] ? fu_tag[i]  : m_ht[i];
                    m_cd[k] = g_byp[k] ? fu_data[i] : m_hd[i];
                end else begin
                    m_cv[k] = 0; m_cs[k] = 0; m_ct[k] = '0; m_cd[k] = '0;
                end
            end
            for (int i = 0; i < NF; i++) begin
                if (hs[i] && !g_bm[i]) begin
                    m_hv[i] = 1; m_ht[i] = fu_tag[i]; m_hd[i] = fu_data[i];
                end else if (g_mask[i]) begin
                    m_hv[i] = 0;
                end
            end
            if (g_n > 0) m_rr = (g_idx[g_n-1] + 1) % NF;
        end
        #1;
    endtask

    task automatic do_flush();
        fu_valid = '0;
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < NF; i++) begin
            fu_valid[i] = 1'b1; fu_tag[i] = TW'(i); fu_data[i] = $urandom;
        end
        step();
        checks++;
        if (cdb_valid !== '0) begin
            errors++;
            $display("FAIL reset_idle: got %b expected 0000", cdb_valid);
        end
        rst = 1'b0;
        step();
        fu_valid = '0;
        repeat (L-1) step();
        for (int k = 0; k < NC; k++) begin
            checks++;
            if (cdb_valid[k] !== 1'b1 || cdb_src[k] !== SW'(k) || cdb_tag[k] !== TW'(k)) begin
                errors++;
                $display("FAIL reset_release lane%0d: got v=%b s=%0d t=%0d expected v=1 s=%0d t=%0d",
                         k, cdb_valid[k], cdb_src[k], cdb_tag[k], k, k);
            end
        end
        repeat (3) step();
    endtask

    task automatic test_single();
        do_flush();
        fu_valid[2] = 1'b1; fu_tag[2] = 4'd5; fu_data[2] = 32'hDEADBEEF;
        step();
        fu_valid = '0;
        checks++;
        if (fu_ready[2] !== 1'b1) begin
            errors++;
            $display("FAIL single_ready: got %b expected 1", fu_ready[2]);
        end
        repeat (L-1) step();
        checks++;
        if (cdb_valid !== 4'b0001 || cdb_tag[0] !== 4'd5 || cdb_data[0] !== 32'hDEADBEEF || cdb_src[0] !== 3'd2) begin
            errors++;
            $display("FAIL single_lane: got v=%b t=%0d d=%h s=%0d expected v=0001 t=5 d=deadbeef s=2",
                     cdb_valid, cdb_tag[0], cdb_data[0], cdb_src[0]);
        end
    endtask

    task automatic test_oversub();
        int seen[NF];
        do_flush();
        for (int i = 0; i < NF; i++) begin
            fu_valid[i] = 1'b1; fu_tag[i] = TW'(i); fu_data[i] = 32'h100 + i; seen[i] = 0;
        end
        step();
        fu_valid = '0;
        repeat (L-1) step();
        checks++;
        if (cdb_valid !== 4'b1111 || cdb_src[0] !== 3'd0 || cdb_src[1] !== 3'd1 ||
            cdb_src[2] !== 3'd2 || cdb_src[3] !== 3'd3) begin
            errors++;
            $display("FAIL oversub_first: got v=%b s=%0d,%0d,%0d,%0d expected v=1111 s=0,1,2,3",
                     cdb_valid, cdb_src[0], cdb_src[1], cdb_src[2], cdb_src[3]);
        end
        for (int k = 0; k < NC; k++) if (cdb_valid[k]) seen[cdb_tag[k]]++;
        step();
        checks++;
        if (cdb_valid !== 4'b0011 || cdb_src[0] !== 3'd4 || cdb_src[1] !== 3'd5) begin
            errors++;
            $display("FAIL oversub_second: got v=%b s=%0d,%0d expected v=0011 s=4,5",
                     cdb_valid, cdb_src[0], cdb_src[1]);
        end
        for (int k = 0; k < NC; k++) if (cdb_valid[k]) seen[cdb_tag[k]]++;
        repeat (2) begin
            step();
            for (int k = 0; k < NC; k++) if (cdb_valid[k]) seen[cdb_tag[k]]++;
        end
        for (int i = 0; i < NF; i++) begin
            checks++;
            if (seen[i] !== 1) begin
                errors++;
                $display("FAIL oversub_once tag%0d: got %0d broadcasts expected 1", i, seen[i]);
            end
        end
    endtask

    task automatic test_back_pressure();
        do_flush();
        fu_valid[0] = 1'b1; fu_tag[0] = 4'd10;
        fu_valid[1] = 1'b1; fu_tag[1] = 4'd11;
        step();
        for (int i = 0; i < NF; i++) begin
            fu_valid[i] = 1'b1; fu_tag[i] = TW'(i); fu_data[i] = $urandom;
        end
        step();
        fu_valid = '0;
        fu_valid[1] = 1'b1; fu_tag[1] = 4'd9; fu_data[1] = 32'h9999_0009;
`ifndef CDB_ARB_BYPASS_EN
        checks++;
        if (fu_ready[1] !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall: got fu_ready1=%b expected 0", fu_ready[1]);
        end
`endif
        step();
`ifndef CDB_ARB_BYPASS_EN
        checks++;
        if (fu_ready[1] !== 1'b1 || cdb_valid !== 4'b1111 || cdb_tag[0] !== 4'd2 || cdb_tag[3] !== 4'd5) begin
            errors++;
            $display("FAIL bp_others: got rdy1=%b v=%b t0=%0d t3=%0d expected rdy1=1 v=1111 t0=2 t3=5",
                     fu_ready[1], cdb_valid, cdb_tag[0], cdb_tag[3]);
        end
`endif
        step();
        fu_valid = '0;
`ifndef CDB_ARB_BYPASS_EN
        checks++;
        if (cdb_valid !== 4'b0011 || cdb_tag[0] !== 4'd0 || cdb_tag[1] !== 4'd1 || cdb_src[1] !== 3'd1) begin
            errors++;
            $display("FAIL bp_old: got v=%b t0=%0d t1=%0d s1=%0d expected v=0011 t0=0 t1=1 s1=1",
                     cdb_valid, cdb_tag[0], cdb_tag[1], cdb_src[1]);
        end
`endif
        step();
`ifndef CDB_ARB_BYPASS_EN
        checks++;
        if (cdb_valid !== 4'b0001 || cdb_tag[0] !== 4'd9 || cdb_src[0] !== 3'd1 || cdb_data[0] !== 32'h9999_0009) begin
            errors++;
            $display("FAIL bp_new: got v=%b t=%0d s=%0d d=%h expected v=0001 t=9 s=1 d=99990009",
                     cdb_valid, cdb_tag[0], cdb_src[0], cdb_data[0]);
        end
`endif
        repeat (2) step();
    endtask

    task automatic test_flush();
        do_flush();
        fu_valid[0] = 1'b1; fu_tag[0] = 4'd12;
        fu_valid[2] = 1'b1; fu_tag[2] = 4'd13;
        fu_valid[4] = 1'b1; fu_tag[4] = 4'd14;
        step();
        fu_valid = '0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (cdb_valid !== '0) begin
                errors++;
                $display("FAIL flush_quiet cycle%0d: got %b expected 0000", c, cdb_valid);
            end
            step();
        end
        fu_valid[5] = 1'b1; fu_tag[5] = 4'd6; fu_data[5] = 32'h0600_0006;
        step();
        fu_valid = '0;
        repeat (L-1) step();
        checks++;
        if (cdb_valid !== 4'b0001 || cdb_tag[0] !== 4'd6 || cdb_src[0] !== 3'd5) begin
            errors++;
            $display("FAIL flush_after: got v=%b t=%0d s=%0d expected v=0001 t=6 s=5",
                     cdb_valid, cdb_tag[0], cdb_src[0]);
        end
    endtask

    task automatic test_bypass_latency();
        logic exp_t1;
        logic exp_t2;
        exp_t1 = BYP;
        exp_t2 = !BYP;
        do_flush();
        fu_valid[3] = 1'b1; fu_tag[3] = 4'd7; fu_data[3] = $urandom;
        step();
        fu_valid = '0;
        checks++;
        if (cdb_valid[0] !== exp_t1 || (exp_t1 && cdb_tag[0] !== 4'd7)) begin
            errors++;
            $display("FAIL latency_t1: got v=%b t=%0d expected v=%b t=7", cdb_valid[0], cdb_tag[0], exp_t1);
        end
        step();
        checks++;
        if (cdb_valid[0] !== exp_t2 || (exp_t2 && cdb_tag[0] !== 4'd7)) begin
            errors++;
            $display("FAIL latency_t2: got v=%b t=%0d expected v=%b t=7", cdb_valid[0], cdb_tag[0], exp_t2);
        end
    endtask

    // FUs keep a presented result stable until it is accepted, then draw a new one.
    task automatic test_random();
        hs = '0;
        fu_valid = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NF; i++) begin
                if (hs[i] || !fu_valid[i]) begin
                    fu_valid[i] = ($urandom_range(0, 99) < 60);
                    fu_tag[i]   = TW'($urandom);
                    fu_data[i]  = $urandom;
                end
            end
            flush = ($urandom_range(0, 49) == 0);
            rst   = ($urandom_range(0, 199) == 0);
            step();
        end
        flush = 1'b0;
        rst   = 1'b0;
        fu_valid = '0;
        repeat (4) step();
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        fu_valid = '0;
        fu_tag = '0;
        fu_data = '0;
        model_clear();
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_oversub();
        test_back_pressure();
        test_flush();
        test_bypass_latency();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the NUM_CDB common-data-bus lanes among NUM_FU functional-unit result ports (ALU, MUL, DIV, LSU, ...).
- Each FU hands a completed result (ROB tag + data) to a one-entry holding register inside the arbiter.
- A round-robin scheduler grants up to NUM_CDB held results per cycle.
- Granted results are driven on registered CDB lanes that feed the reservation stations and the ROB.

Parameters:
- NUM_FU, 6, number of requesting functional units.
- NUM_CDB, 4, number of CDB broadcast lanes (NUM_CDB <= NUM_FU).
- ROB_DEPTH, 16, ROB entries; TAG_W = $clog2(ROB_DEPTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  branch-mispredict flush; synchronous, same effect as rst on all state.
- fu_valid[NUM_FU]  in  1 each  FU presents a result.
- fu_tag[NUM_FU]  in  TAG_W each  destination ROB tag of the result.
- fu_data[NUM_FU]  in  32 each  result value.
- fu_ready[NUM_FU]  out  1 each  arbiter accepts the result this cycle.
- cdb_valid[NUM_CDB]  out  1 each  lane carries a valid broadcast.
- cdb_tag[NUM_CDB]  out  TAG_W each  ROB tag on lane.
- cdb_data[NUM_CDB]  out  32 each  data on lane.
- cdb_src[NUM_CDB]  out  $clog2(NUM_FU) each  index of the FU that owns the lane (debug/perf).

Behaviour:
- State:
  - per-FU hold_valid/hold_tag/hold_data;
  - rr_ptr ($clog2(NUM_FU) bits);
  - registered cdb_* lane outputs.
- Reset/flush: hold_valid all 0, rr_ptr = 0, cdb_valid all 0, cdb_tag/cdb_data/cdb_src all 0. Any fu_valid during a rst/flush cycle is dropped.
- Grant (combinational):
  - Scan FU indices rr_ptr, rr_ptr+1, ... mod NUM_FU, once each.
  - The first NUM_CDB indices with hold_valid=1 are granted, in scan order.
  - The k-th granted entry maps to lane k.
  - Lanes beyond the grant count are idle.
- fu_ready[i] = ~hold_valid[i] | grant[i], combinational; must not depend on fu_valid[i].
- Handshake: fu_valid[i] & fu_ready[i] at an edge loads hold[i]. Simultaneous grant and load on the same FU: the new result replaces the granted one, and hold_valid stays 1.
- FU obligation: fu_valid/tag/data stay stable until fu_ready is sampled high.
- Lane register at each edge: cdb_valid[k] = 1 iff lane k granted. tag/data/src are loaded from the granted hold; otherwise tag/data/src are 0.
- Latency: FU handshake in cycle t → hold in t+1 → earliest cdb_valid in t+2. Worst-case wait in hold is ceil(NUM_FU/NUM_CDB) grant cycles.
- rr_ptr update:
  - If any grant, rr_ptr = (index of last granted FU + 1) mod NUM_FU.
  - If none, rr_ptr is unchanged.
  - Wrap from NUM_FU-1 to 0 is explicit; arithmetic must not rely on power-of-two NUM_FU.
- Fewer than NUM_CDB holders: all are granted the same cycle, and lanes 0..n-1 are contiguous.
- All FUs holding: exactly NUM_CDB grants. No FU is starved across ceil(NUM_FU/NUM_CDB) consecutive cycles.
- One result is broadcast exactly once. No duplicate tag appears on two lanes in the same cycle unless two FUs present the same tag, which is illegal upstream.

Optional Feature:
- Macro CDB_ARB_BYPASS_EN.
- Defined:
  - An FU with hold_valid=0 and fu_valid=1 joins the same round-robin scan as a candidate.
  - If granted, its input goes straight to the lane register (latency 1: handshake t, cdb_valid t+1) and hold is not loaded.
  - Held entries and bypass candidates share the single rr order.
  - fu_ready stays as defined above; a bypass-granted FU also sees fu_ready=1.
- Undefined: no bypass; latency is 2 as above.

Test Plan:
- Reset/flush:
  - Hold rst 1 cycle with all fu_valid=1 → next cycle every cdb_valid=0 and rr_ptr=0.
  - Release → lanes 0-3 carry FU0-3 two cycles later.
- Single requester: FU2 sends tag 5, data 0xDEADBEEF → two cycles later cdb_valid[0]=1, tag 5, data 0xDEADBEEF, src 2; lanes 1-3 idle; fu_ready[2] stays 1.
- Oversubscription:
  - All 6 FUs valid with tags 0-5 → cycle A lanes = FU0,1,2,3, then rr_ptr=4.
  - Cycle A+1 lanes = FU4,5, plus any refilled FU0,1.
  - Every tag is broadcast exactly once.
- Back-pressure: FU1 holds while 4 others win; FU1 keeps fu_valid with a new tag 9 → fu_ready[1]=0 until granted, then tag 9 is accepted the same edge as the old tag is broadcast.
- Mid-operation flush: 3 results held, flush asserted → the next cycle has no broadcast of any of them; tags seen afterwards come only from post-flush handshakes.
- CDB_ARB_BYPASS_EN: empty arbiter, FU3 tag 7 at cycle t → cdb_valid[0]=1 with tag 7 at t+1. With the macro undefined → at t+2.
